axi_s5_master: RTL and testbench

AXI_S5_MASTER -- requirements
Module: axi_s5_master

---
 rtl/axi_s5_master.sv | 228 ++++++++++++++++++++++
 tb/tb_axi_s5_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_s5_master.sv
// AXI4 master for the slave 5 window: one burst outstanding, address/range check, response folding.
// Latency: 1 cycle from command accept to awvalid/arvalid; a range reject gives done 1 cycle after accept.
// Backpressure: cmd_ready only in IDLE; the write stream follows wready; read beats have no backpressure. Stats: AXI_S5_MST_STATS_EN.
module axi_s5_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_A000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [11:0] cmd_offset,
    input  logic [7:0]  cmd_len,
    input  logic [5:0]  cmd_id,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,
    input  logic [3:0]  wd_strb,
    output logic        rd_valid,
    output logic        rd_last,
    output logic [31:0] rd_data,
    output logic        done,
    output logic [1:0]  done_resp,
    output logic        done_rangeerr,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic [15:0] err_count,
    output logic [5:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic [3:0]  awqos,
    output logic [3:0]  awregion,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [5:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [5:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic [3:0]  arqos,
    output logic [3:0]  arregion,
    output logic        arvalid,
    input  logic        arready,
    input  logic [5:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);
    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

    state_t      state, state_nxt;
    logic [11:0] offset_q;
    logic [7:0]  len_q;
    logic [5:0]  id_q;
    logic [7:0]  beat_q;
    logic [1:0]  resp_q;
    logic [1:0]  r_resp_nxt;
    logic        rangeerr_q;
    logic [12:0] cmd_end;
    logic        cmd_bad;
    logic        unused_rid;

    // Read beats are not matched on rid: only one burst is ever outstanding.
    assign unused_rid = ^rid;

    assign cmd_end = {1'b0, cmd_offset} + {3'b000, cmd_len, 2'b00};
    assign cmd_bad = (cmd_offset[1:0] != 2'b00) || (cmd_end > 13'h0FFF);

    assign awid     = id_q;
    assign awaddr   = BASE_ADDR | {20'd0, offset_q};
    assign awlen    = len_q;
    assign awsize   = 3'b010;
    assign awburst  = 2'b01;
    assign awlock   = 1'b0;
    assign awcache  = 4'd0;
    assign awprot   = 3'd0;
    assign awqos    = 4'd0;
    assign awregion = 4'd0;
    assign arid     = id_q;
    assign araddr   = BASE_ADDR | {20'd0, offset_q};
    assign arlen    = len_q;
    assign arsize   = 3'b010;
    assign arburst  = 2'b01;
    assign arlock   = 1'b0;
    assign arcache  = 4'd0;
    assign arprot   = 3'd0;
    assign arqos    = 4'd0;
    assign arregion = 4'd0;

    assign wdata         = wd_data;
    assign wstrb         = wd_strb;
    assign wlast         = (state == W) && (beat_q == len_q);
    assign rd_data       = rdata;
    assign rd_last       = (state == R) && rlast;
    assign done_resp     = done ? resp_q : 2'b00;
    assign done_rangeerr = done && rangeerr_q;

    // Worst-case response so far, with a misplaced or missing rlast forced to SLVERR.
    always_comb begin
        r_resp_nxt = (rresp > resp_q) ? rresp : resp_q;
        if ((rlast != (beat_q == len_q)) && (r_resp_nxt < 2'b10))
            r_resp_nxt = 2'b10;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        arvalid   = 1'b0;
        wvalid    = 1'b0;
        wd_ready  = 1'b0;
        bready    = 1'b0;
        rready    = 1'b0;
        rd_valid  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid)
                    state_nxt = cmd_bad ? DONE : (cmd_write ? AW : AR);
            end
            AW: begin
                awvalid = 1'b1;
                if (awready) state_nxt = W;
            end
            W: begin
                wvalid   = wd_valid;
                wd_ready = wready;
                if (wd_valid && wready && wlast) state_nxt = B;
            end
            B: begin
                bready = 1'b1;
                if (bvalid) state_nxt = DONE;
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = R;
            end
            R: begin
                rready   = 1'b1;
                rd_valid = rvalid;
                if (rvalid && rlast) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            offset_q   <= 12'd0;
            len_q      <= 8'd0;
            id_q       <= 6'd0;
            beat_q     <= 8'd0;
            resp_q     <= 2'b00;
            rangeerr_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (cmd_valid) begin
                    offset_q   <= cmd_offset;
                    len_q      <= cmd_len;
                    id_q       <= cmd_id;
                    beat_q     <= 8'd0;
                    rangeerr_q <= cmd_bad;
                    resp_q     <= cmd_bad ? 2'b10 : 2'b00;
                end
                W: if (wd_valid && wready) beat_q <= beat_q + 8'd1;
                B: if (bvalid) resp_q <= (bid == id_q) ? bresp : 2'b10;
                R: if (rvalid) begin
                    beat_q <= beat_q + 8'd1;
                    resp_q <= r_resp_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef AXI_S5_MST_STATS_EN
    logic [15:0] wr_cnt_q, rd_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q  <= 16'd0;
            rd_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            if (state == B && bvalid && wr_cnt_q != 16'hFFFF)
                wr_cnt_q <= wr_cnt_q + 16'd1;
            if (state == R && rvalid && rlast && rd_cnt_q != 16'hFFFF)
                rd_cnt_q <= rd_cnt_q + 16'd1;
            if (done && resp_q != 2'b00 && err_cnt_q != 16'hFFFF)
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign wr_count  = wr_cnt_q;
    assign rd_count  = rd_cnt_q;
    assign err_count = err_cnt_q;
`else
    assign wr_count  = 16'd0;
    assign rd_count  = 16'd0;
    assign err_count = 16'd0;
`endif
endmodule

// File: tb/tb_axi_s5_master.sv
// Directed plus randomized bursts against axi_s5_master; a bench-side model derives address, beats and responses.
module tb_axi_s5_master;
    localparam logic [31:0] BASE = 32'h0000_A000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 0, cmd_write = 0;
    logic [11:0] cmd_offset = 0;
    logic [7:0] cmd_len = 0;
    logic [5:0] cmd_id = 0;
    logic wd_valid = 0;
    logic [31:0] wd_data = 0;
    logic [3:0] wd_strb = 0;
    logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0, rlast = 0;
    logic [5:0] bid = 0, rid = 0;
    logic [1:0] bresp = 0, rresp = 0;
    logic [31:0] rdata = 0;

    logic cmd_ready, wd_ready, rd_valid, rd_last, done, done_rangeerr;
    logic [31:0] rd_data;
    logic [1:0] done_resp;
    logic [15:0] wr_count, rd_count, err_count;
    logic [5:0] awid, arid;
    logic [31:0] awaddr, araddr, wdata;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize, awprot, arprot;
    logic [1:0] awburst, arburst;
    logic awlock, arlock, awvalid, arvalid, wlast, wvalid, bready, rready;
    logic [3:0] awcache, awqos, awregion, arcache, arqos, arregion, wstrb;

    int n_tests = 0;
    int n_fail = 0;
    int wr_m = 0, rd_m = 0, err_m = 0;

    axi_s5_master #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_offset(cmd_offset), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_last(rd_last), .rd_data(rd_data),
        .done(done), .done_resp(done_resp), .done_rangeerr(done_rangeerr),
        .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos), .awregion(awregion),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos), .arregion(arregion),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (observed running, expected finished)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters();
`ifdef AXI_S5_MST_STATS_EN
        check("wr_count", wr_count, wr_m);
        check("rd_count", rd_count, rd_m);
        check("err_count", err_count, err_m);
`else
        check("wr_count", wr_count, 0);
        check("rd_count", rd_count, 0);
        check("err_count", err_count, 0);
`endif
    endtask

    // One command end to end, playing the AXI slave; expectations come from the window/beat rules.
    task automatic run_txn(input bit wr, input logic [11:0] off, input logic [7:0] len,
                           input logic [5:0] id, input int addr_dly, input bit rnd_hs,
                           input logic [1:0] bresp_v, input bit bid_bad,
                           input int rerr_beat, input logic [1:0] rerr_val, input int rlast_at);
        bit bad;
        logic [1:0] exp_resp;
        int beat, budget, gap;
        bad = (off[1:0] != 2'b00) || (int'(off) + 4 * int'(len) > 4095);
        exp_resp = 2'b00;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_offset = off; cmd_len = len; cmd_id = id;
        #1 check("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 0; cmd_offset = 12'($urandom); cmd_len = 8'($urandom); cmd_id = 6'($urandom);
        #1;
        if (bad) begin
            exp_resp = 2'b10;
            check("reject_no_axi", {awvalid, arvalid}, 0);
        end else if (wr) begin
            for (int k = 0; k <= addr_dly; k++) begin
                if (k > 0) @(negedge clk);
                awready = (k == addr_dly);
                #1;
                check("awvalid", awvalid, 1);
                check("awaddr", awaddr, BASE | {20'd0, off});
                check("awlen", awlen, len);
                check("aw_fixed", {awid, awsize, awburst}, {id, 3'b010, 2'b01});
                check("aw_attr", {awlock, awcache, awprot, awqos, awregion}, 0);
            end
            @(negedge clk);
            awready = 0;
            beat = 0; budget = 0;
            while (beat <= int'(len) && budget < 400) begin
                wd_valid = rnd_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
                wready   = rnd_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
                wd_data  = $urandom;
                wd_strb  = 4'($urandom);
                #1;
                check("wvalid_pass", wvalid, wd_valid);
                check("wd_ready_pass", wd_ready, wready);
                if (wd_valid && wready) begin
                    check("wdata", {wstrb, wdata}, {wd_strb, wd_data});
                    check("wlast", wlast, beat == int'(len));
                    beat++;
                end
                budget++;
                @(negedge clk);
            end
            wd_valid = 0; wready = 0;
            check("w_beats", beat, int'(len) + 1);
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) begin
                #1 check("bready_wait", {bready, done}, 2'b10);
                @(negedge clk);
            end
            bvalid = 1; bresp = bresp_v; bid = bid_bad ? (id ^ 6'h01) : id;
            #1 check("bready", bready, 1);
            @(negedge clk);
            bvalid = 0;
            exp_resp = bid_bad ? 2'b10 : bresp_v;
            #1;
        end else begin
            for (int k = 0; k <= addr_dly; k++) begin
                if (k > 0) @(negedge clk);
                arready = (k == addr_dly);
                #1;
                check("arvalid", arvalid, 1);
                check("araddr", araddr, BASE | {20'd0, off});
                check("arlen", arlen, len);
                check("ar_fixed", {arid, arsize, arburst}, {id, 3'b010, 2'b01});
                check("ar_attr", {arlock, arcache, arprot, arqos, arregion}, 0);
            end
            @(negedge clk);
            arready = 0;
            for (int i = 0; i <= rlast_at; i++) begin
                gap = rnd_hs ? $urandom_range(0, 2) : 0;
                for (int g = 0; g < gap; g++) begin
                    rvalid = 0;
                    #1 check("r_gap", {rready, rd_valid}, 2'b10);
                    @(negedge clk);
                end
                rvalid = 1; rid = id; rdata = $urandom;
                rresp = (i == rerr_beat) ? rerr_val : 2'b00;
                rlast = (i == rlast_at);
                #1;
                check("rd_valid", {rready, rd_valid}, 2'b11);
                check("rd_data", rd_data, rdata);
                check("rd_last", rd_last, rlast);
                if (rresp > exp_resp) exp_resp = rresp;
                @(negedge clk);
            end
            rvalid = 0; rlast = 0; rresp = 0;
            if (rlast_at != int'(len) && exp_resp < 2'b10) exp_resp = 2'b10;
            #1;
        end
        check("done", done, 1);
        check("done_resp", done_resp, exp_resp);
        check("done_rangeerr", done_rangeerr, bad);
        if (!bad) begin
            if (wr) wr_m++;
            else rd_m++;
        end
        if (exp_resp != 2'b00) err_m++;
        @(negedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("back_idle", cmd_ready, 1);
        check_counters();
    endtask

    initial begin
        bit r_wr, r_bidbad;
        logic [11:0] r_off;
        logic [9:0] r_w;
        logic [7:0] r_len;
        logic [1:0] r_bresp, r_rerrv;
        int sel, r_rlast, r_rerr;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_valids", {awvalid, arvalid, wvalid, bready, rready, wd_ready, rd_valid}, 0);
        check("rst_done", {done, done_resp, done_rangeerr}, 0);
        check_counters();
        rst = 0;

        run_txn(1, 12'h010, 8'd3, 6'd5, 0, 0, 2'b00, 0, -1, 2'b00, 0);
        run_txn(0, 12'hFFC, 8'd0, 6'd7, 0, 0, 2'b00, 0, -1, 2'b00, 0);
        run_txn(1, 12'hFF8, 8'd2, 6'd1, 0, 0, 2'b00, 0, -1, 2'b00, 0);
        run_txn(0, 12'h100, 8'd3, 6'd2, 0, 0, 2'b00, 0, 2, 2'b10, 3);
        run_txn(1, 12'h200, 8'd1, 6'd3, 5, 0, 2'b00, 0, -1, 2'b00, 0);
        run_txn(1, 12'h040, 8'd2, 6'd4, 1, 1, 2'b00, 1, -1, 2'b00, 0);
        run_txn(0, 12'h080, 8'd4, 6'd9, 2, 1, 2'b00, 0, -1, 2'b00, 2);
        run_txn(0, 12'h0C0, 8'd2, 6'd9, 0, 1, 2'b00, 0, 1, 2'b11, 3);
        run_txn(0, 12'h002, 8'd0, 6'd8, 0, 0, 2'b00, 0, -1, 2'b00, 0);
        run_txn(1, 12'hFF0, 8'd3, 6'd6, 0, 0, 2'b01, 0, -1, 2'b00, 0);

        // Reset in the middle of a 4-beat write, after 2 beats.
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_offset = 12'h300; cmd_len = 8'd3; cmd_id = 6'd11;
        @(negedge clk);
        cmd_valid = 0; awready = 1;
        #1 check("mid_awvalid", awvalid, 1);
        @(negedge clk);
        awready = 0; wd_valid = 1; wready = 1;
        #1 check("mid_beat0", wvalid, 1);
        @(negedge clk);
        #1 check("mid_beat1", wvalid, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        check("abort_wvalid", wvalid, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_no_done", done, 0);
        wd_valid = 0; wready = 0;
        wr_m = 0; rd_m = 0; err_m = 0;
        check_counters();
        @(negedge clk);
        #1 check("abort_still_no_done", done, 0);

        for (int t = 0; t < 12; t++) begin
            r_wr = 1'($urandom);
            r_len = 8'($urandom_range(0, 15));
            r_w = 10'($urandom);
            r_off = {r_w, 2'b00};
            sel = $urandom_range(0, 5);
            if (sel == 0) r_off[1:0] = 2'($urandom_range(1, 3));
            if (sel == 1) r_off = 12'hFC0 | {6'd0, r_w[3:0], 2'b00};
            sel = $urandom_range(0, 5);
            r_rlast = int'(r_len);
            if (sel == 0) r_rlast = int'(r_len) + 1;
            if (sel == 1 && r_len > 0) r_rlast = int'(r_len) - 1;
            r_rerr = $urandom_range(0, int'(r_len) + 2);
            r_rerrv = 2'($urandom);
            r_bresp = 2'($urandom);
            r_bidbad = ($urandom_range(0, 5) == 0);
            run_txn(r_wr, r_off, r_len, 6'($urandom), $urandom_range(0, 3), 1,
                    r_bresp, r_bidbad, r_rerr, r_rerrv, r_rlast);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
